// File: rtl/rggen_address_decoder_array.sv
// Registered multi-window address decoder and access sequencer for the rggen register-block bus.
// One request at a time: decode, select a window, wait for its ack (or a timeout), then respond.
module rggen_address_decoder_array #(
    parameter int                       WINDOWS         = 4,
    parameter int                       WIDTH           = 8,
    parameter int                       BUS_WIDTH       = 32,
    parameter logic [WINDOWS*WIDTH-1:0] START_ADDRESSES = '0,
    parameter logic [WINDOWS*WIDTH-1:0] END_ADDRESSES   = '0,
    parameter logic [WINDOWS-1:0]       READABLE_MASK   = '1,
    parameter logic [WINDOWS-1:0]       WRITABLE_MASK   = '1,
    parameter int                       TIMEOUT_CYCLES  = 16,
    parameter int                       INDEX_WIDTH     = (WINDOWS > 1) ? $clog2(WINDOWS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_request_valid,
    output logic                   o_request_ready,
    input  logic [WIDTH-1:0]       i_address,
    input  logic [1:0]             i_access,
    output logic [WINDOWS-1:0]     o_select,
    input  logic [WINDOWS-1:0]     i_window_ack,
    output logic                   o_response_valid,
    input  logic                   i_response_ready,
    output logic [1:0]             o_response_status,
    output logic [INDEX_WIDTH-1:0] o_response_index
);

    localparam int LSB         = $clog2(BUS_WIDTH) - 3;
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT =
        COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] STATUS_OKAY    = 2'b00;
    localparam logic [1:0] STATUS_DECODE  = 2'b01;
    localparam logic [1:0] STATUS_ACCESS  = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_e;

    state_e                 r_state;
    state_e                 w_nextState;
    logic [WINDOWS-1:0]     r_select;
    logic [WINDOWS-1:0]     w_nextSelect;
    logic                   r_responseValid;
    logic                   w_nextResponseValid;
    logic [1:0]             r_status;
    logic [1:0]             w_nextStatus;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [INDEX_WIDTH-1:0] w_nextIndex;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_nextCount;

    logic                   w_hit;
    logic                   w_allowed;
    logic [INDEX_WIDTH-1:0] w_hitIndex;
    logic                   w_selectedAck;
    logic                   w_unused;

    assign w_unused = ^{i_access[1], i_address};

    // Scan from the top so the lowest-indexed overlapping window is the last writer and wins.
    always_comb begin
        w_hit      = 1'b0;
        w_allowed  = 1'b0;
        w_hitIndex = '0;
        for (int i = WINDOWS - 1; i >= 0; i--) begin
            if ((i_address[WIDTH-1:LSB] >= START_ADDRESSES[i*WIDTH+LSB +: WIDTH-LSB]) &&
                (i_address[WIDTH-1:LSB] <= END_ADDRESSES[i*WIDTH+LSB +: WIDTH-LSB])) begin
                w_hit      = 1'b1;
                w_hitIndex = INDEX_WIDTH'(i);
                w_allowed  = i_access[0] ? WRITABLE_MASK[i] : READABLE_MASK[i];
            end
        end
    end

    assign w_selectedAck = |(i_window_ack & r_select);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_select        <= '0;
            r_responseValid <= 1'b0;
            r_status        <= STATUS_OKAY;
            r_index         <= '0;
            r_count         <= '0;
        end else begin
            r_state         <= w_nextState;
            r_select        <= w_nextSelect;
            r_responseValid <= w_nextResponseValid;
            r_status        <= w_nextStatus;
            r_index         <= w_nextIndex;
            r_count         <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState         = r_state;
        w_nextSelect        = r_select;
        w_nextResponseValid = r_responseValid;
        w_nextStatus        = r_status;
        w_nextIndex         = r_index;
        w_nextCount         = r_count;
        case (r_state)
            IDLE: begin
                if (i_request_valid) begin
                    w_nextIndex = w_hitIndex;
                    if (w_hit && w_allowed) begin
                        w_nextState  = ACCESS;
                        w_nextSelect = WINDOWS'(1) << w_hitIndex;
                        w_nextCount  = '0;
                    end else begin
                        w_nextState         = RESPOND;
                        w_nextResponseValid = 1'b1;
                        w_nextStatus        = w_hit ? STATUS_ACCESS : STATUS_DECODE;
                    end
                end
            end
            ACCESS: begin
                // Saturate so a disabled timeout can never wrap the counter.
                if (r_count != '1) begin
                    w_nextCount = r_count + 1'b1;
                end
                if (w_selectedAck) begin
                    w_nextState         = RESPOND;
                    w_nextSelect        = '0;
                    w_nextResponseValid = 1'b1;
                    w_nextStatus        = STATUS_OKAY;
                end else if ((TIMEOUT_CYCLES > 0) && (r_count == LAST_COUNT)) begin
                    w_nextState         = RESPOND;
                    w_nextSelect        = '0;
                    w_nextResponseValid = 1'b1;
                    w_nextStatus        = STATUS_TIMEOUT;
                end
            end
            RESPOND: begin
                if (i_response_ready) begin
                    w_nextState         = IDLE;
                    w_nextResponseValid = 1'b0;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign o_request_ready   = (r_state == IDLE);
    assign o_select          = r_select;
    assign o_response_valid  = r_responseValid;
    assign o_response_status = r_status;
    assign o_response_index  = r_index;

endmodule

// File: tb/tb_rggen_address_decoder_array.sv
// Self-checking bench for rggen_address_decoder_array: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_rggen_address_decoder_array;

    localparam int WINDOWS = 4;
    localparam int TIMEOUT = 16;
    localparam int WIN_START [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
    localparam int WIN_END   [4] = '{8'h0F, 8'h13, 8'h2F, 8'h3F};
    localparam int WIN_WRITE [4] = '{1, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_request_valid = 1'b0;
    logic       o_request_ready;
    logic [7:0] i_address = '0;
    logic [1:0] i_access = '0;
    logic [3:0] o_select;
    logic [3:0] i_window_ack = '0;
    logic       o_response_valid;
    logic       i_response_ready = 1'b1;
    logic [1:0] o_response_status;
    logic [1:0] o_response_index;

    int checks = 0;
    int failures = 0;

    rggen_address_decoder_array #(
        .WINDOWS        (WINDOWS),
        .WIDTH          (8),
        .BUS_WIDTH      (32),
        .START_ADDRESSES({8'h30, 8'h20, 8'h10, 8'h00}),
        .END_ADDRESSES  ({8'h3F, 8'h2F, 8'h13, 8'h0F}),
        .READABLE_MASK  (4'b1111),
        .WRITABLE_MASK  (4'b1011),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_request_valid  (i_request_valid),
        .o_request_ready  (o_request_ready),
        .i_address        (i_address),
        .i_access         (i_access),
        .o_select         (o_select),
        .i_window_ack     (i_window_ack),
        .o_response_valid (o_response_valid),
        .i_response_ready (i_response_ready),
        .o_response_status(o_response_status),
        .o_response_index (o_response_index)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: byte ranges compared in word units, first matching window wins.
    function automatic void decodeRequest(input int addr, input bit isWrite,
                                          output int status, output int index);
        status = 1;
        index  = 0;
        for (int w = 3; w >= 0; w--) begin
            if ((addr / 4 >= WIN_START[w] / 4) && (addr / 4 <= WIN_END[w] / 4)) begin
                index  = w;
                status = (isWrite && WIN_WRITE[w] == 0) ? 2 : 0;
            end
        end
    endfunction

    int expSelect = 0;
    int expValid = 0;
    int expStatus = 0;
    int expIndex = 0;
    bit waitingAck = 0;
    int elapsed = 0;

    always @(posedge clk or negedge rst_n) begin
        int st;
        int idx;
        if (!rst_n) begin
            expSelect  = 0;
            expValid   = 0;
            expStatus  = 0;
            expIndex   = 0;
            waitingAck = 0;
            elapsed    = 0;
        end else if (expValid != 0) begin
            if (i_response_ready) expValid = 0;
        end else if (waitingAck) begin
            elapsed++;
            if (((int'(i_window_ack) >> expIndex) & 1) == 1) begin
                waitingAck = 0; expSelect = 0; expValid = 1; expStatus = 0;
            end else if (elapsed == TIMEOUT) begin
                waitingAck = 0; expSelect = 0; expValid = 1; expStatus = 3;
            end
        end else if (i_request_valid) begin
            decodeRequest(int'(i_address), i_access[0], st, idx);
            expIndex = idx;
            if (st == 0) begin
                waitingAck = 1;
                elapsed    = 0;
                expSelect  = 1 << idx;
            end else begin
                expValid  = 1;
                expStatus = st;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("select", int'(o_select), expSelect);
        checkOutput("responseValid", int'(o_response_valid), expValid);
        checkOutput("requestReady", int'(o_request_ready), (!waitingAck && expValid == 0) ? 1 : 0);
        if (expValid != 0) begin
            checkOutput("responseStatus", int'(o_response_status), expStatus);
            checkOutput("responseIndex", int'(o_response_index), expIndex);
        end
    end

    task automatic applyStimulus(input logic [7:0] addr, input logic isWrite);
        int waited = 0;
        i_request_valid = 1'b1;
        i_address       = addr;
        i_access        = {1'b0, isWrite};
        while (!o_request_ready && waited < 50) begin
            tick();
            waited++;
        end
        checkOutput("acceptWait", int'(o_request_ready), 1);
        tick();
        i_request_valid = 1'b0;
    endtask

    task automatic measureSelect(output int highCycles);
        highCycles = 0;
        while (o_select != 4'b0000 && highCycles < 40) begin
            highCycles++;
            tick();
        end
    endtask

    initial begin
        int highCycles;

        // Reset values
        tick();
        tick();
        checkOutput("resetSelect", int'(o_select), 0);
        checkOutput("resetValid", int'(o_response_valid), 0);
        checkOutput("resetStatus", int'(o_response_status), 0);
        checkOutput("resetIndex", int'(o_response_index), 0);
        checkOutput("resetReady", int'(o_request_ready), 1);
        rst_n = 1'b1;
        tick();

        // Read 0x12, ack three cycles after acceptance
        applyStimulus(8'h12, 1'b0);
        checkOutput("read12SelectT1", int'(o_select), 4'b0010);
        tick();
        tick();
        checkOutput("read12SelectT3", int'(o_select), 4'b0010);
        i_window_ack = 4'b0010;
        tick();
        i_window_ack = 4'b0000;
        checkOutput("read12Select", int'(o_select), 0);
        checkOutput("read12Valid", int'(o_response_valid), 1);
        checkOutput("read12Status", int'(o_response_status), 0);
        checkOutput("read12Index", int'(o_response_index), 1);
        tick();

        // Gap address decodes to an error
        applyStimulus(8'h1A, 1'b0);
        checkOutput("gapSelect", int'(o_select), 0);
        checkOutput("gapValid", int'(o_response_valid), 1);
        checkOutput("gapStatus", int'(o_response_status), 1);
        checkOutput("gapIndex", int'(o_response_index), 0);
        tick();

        // 0x13 lands in window 1 since the low two bits are ignored; minimum-latency transaction
        applyStimulus(8'h13, 1'b0);
        checkOutput("low13Select", int'(o_select), 4'b0010);
        i_window_ack = 4'b0010;
        tick();
        i_window_ack = 4'b0000;
        checkOutput("low13Status", int'(o_response_status), 0);
        checkOutput("low13Index", int'(o_response_index), 1);
        tick();
        checkOutput("minTxnReady", int'(o_request_ready), 1);

        // Write to a read-only window, then a legal read of the same address
        applyStimulus(8'h24, 1'b1);
        checkOutput("wr24Select", int'(o_select), 0);
        checkOutput("wr24Status", int'(o_response_status), 2);
        checkOutput("wr24Index", int'(o_response_index), 2);
        tick();
        applyStimulus(8'h24, 1'b0);
        checkOutput("rd24Select", int'(o_select), 4'b0100);
        i_window_ack = 4'b0100;
        tick();
        i_window_ack = 4'b0000;
        checkOutput("rd24Status", int'(o_response_status), 0);
        tick();

        // No ack: select stays up for exactly the timeout, then a timeout response
        applyStimulus(8'h30, 1'b0);
        measureSelect(highCycles);
        checkOutput("timeoutSelectCycles", highCycles, 16);
        checkOutput("timeoutStatus", int'(o_response_status), 3);
        checkOutput("timeoutIndex", int'(o_response_index), 3);
        tick();

        // Ack arriving in the last allowed cycle still completes OKAY
        applyStimulus(8'h30, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("lastCycleSelect", int'(o_select), 4'b1000);
        i_window_ack = 4'b1000;
        tick();
        i_window_ack = 4'b0000;
        checkOutput("lastCycleStatus", int'(o_response_status), 0);
        tick();

        // Ack on unselected windows is ignored
        i_window_ack = 4'b0111;
        applyStimulus(8'h3C, 1'b0);
        measureSelect(highCycles);
        i_window_ack = 4'b0000;
        checkOutput("wrongAckCycles", highCycles, 16);
        checkOutput("wrongAckStatus", int'(o_response_status), 3);
        tick();

        // Consumer stalls for five cycles while a new request waits
        i_response_ready = 1'b0;
        applyStimulus(8'h04, 1'b0);
        i_window_ack = 4'b0001;
        tick();
        i_window_ack    = 4'b0000;
        i_request_valid = 1'b1;
        i_address       = 8'h30;
        i_access        = 2'b00;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallValid", int'(o_response_valid), 1);
            checkOutput("stallStatus", int'(o_response_status), 0);
            checkOutput("stallIndex", int'(o_response_index), 0);
            checkOutput("stallReady", int'(o_request_ready), 0);
            i_address = 8'h30 + 8'(i);
            tick();
        end
        i_response_ready = 1'b1;
        i_address        = 8'h30;
        tick();
        checkOutput("postStallReady", int'(o_request_ready), 1);
        checkOutput("postStallSelect", int'(o_select), 0);
        tick();
        i_request_valid = 1'b0;
        checkOutput("queuedSelect", int'(o_select), 4'b1000);
        i_window_ack = 4'b1000;
        tick();
        i_window_ack = 4'b0000;
        checkOutput("queuedStatus", int'(o_response_status), 0);
        tick();

        // Asynchronous reset in the middle of an access
        applyStimulus(8'h04, 1'b0);
        checkOutput("preResetSelect", int'(o_select), 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetSelect", int'(o_select), 0);
        checkOutput("asyncResetValid", int'(o_response_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("afterResetReady", int'(o_request_ready), 1);
        applyStimulus(8'h38, 1'b0);
        checkOutput("freshSelect", int'(o_select), 4'b1000);
        i_window_ack = 4'b1000;
        tick();
        i_window_ack = 4'b0000;
        checkOutput("freshStatus", int'(o_response_status), 0);
        checkOutput("freshIndex", int'(o_response_index), 3);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got 0x0, expected 0x1 (bench did not complete)");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rggen_address_decoder_array.md
Name: rggen_address_decoder_array

Overview:
Multi-window registered address decoder and access sequencer for the rggen register-block bus.
- Accepts one bus request at a time over a valid/ready handshake.
- Decodes the address against WINDOWS inclusive address ranges, each with its own read/write permission.
- Drives a one-hot select to the matching window and waits for that window's acknowledge, bounded by a timeout.
- Returns a status response over a second valid/ready handshake.
- Sits between the bus adapter and the per-register blocks. It replaces per-register combinational match logic with one sequenced decoder.

Parameters:
WINDOWS, 4, number of address windows (>=1)
WIDTH, 8, address width in bits
BUS_WIDTH, 32, data bus width; sets ignored low address bits LSB = clog2(BUS_WIDTH)-3
START_ADDRESSES, {WINDOWS*WIDTH{1'b0}}, packed start byte addresses; window i at [i*WIDTH +: WIDTH]
END_ADDRESSES, {WINDOWS*WIDTH{1'b0}}, packed inclusive end byte addresses, same packing
READABLE_MASK, {WINDOWS{1'b1}}, bit i=1: window i permits reads
WRITABLE_MASK, {WINDOWS{1'b1}}, bit i=1: window i permits writes
TIMEOUT_CYCLES, 16, maximum cycles spent in ACCESS before a timeout response; 0 disables the timeout
INDEX_WIDTH, derived, max(1, clog2(WINDOWS))

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_request_valid  input  1  request present
o_request_ready  output  1  decoder accepts a request
i_address  input  WIDTH  request byte address
i_access  input  2  access type; bit0=1 write, bit0=0 read; bit1 unused
o_select  output  WINDOWS  registered one-hot window select
i_window_ack  input  WINDOWS  per-window completion acknowledge
o_response_valid  output  1  response present
i_response_ready  input  1  response consumer ready
o_response_status  output  2  00 OKAY, 01 DECODE_ERROR, 10 ACCESS_ERROR, 11 TIMEOUT
o_response_index  output  INDEX_WIDTH  window index of the response

Behaviour:
- Reset (async assert, sync release to IDLE):
  - o_select=0, o_response_valid=0, o_response_status=00, o_response_index=0.
  - Timeout counter=0.
  - o_request_ready=1, because it is combinational (state==IDLE).
- Address match:
  - Window i hits when START_i[WIDTH-1:LSB] <= i_address[WIDTH-1:LSB] <= END_i[WIDTH-1:LSB].
  - Bits below LSB are ignored.
  - If windows overlap, the lowest index wins.
- Access match:
  - Read requires READABLE_MASK[i]; write requires WRITABLE_MASK[i].
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - Request accepted on i_request_valid && o_request_ready (cycle T).
  - Hit with permitted access -> ACCESS. o_select=onehot(i) from T+1. Counter cleared. Index latched.
  - Hit with access not permitted -> RESPOND. Status 10, index=i, o_response_valid from T+1. o_select stays 0.
  - No hit -> RESPOND. Status 01, index 0, o_response_valid from T+1.
- ACCESS:
  - o_select is held constant. The counter increments every cycle.
  - Only i_window_ack[selected] counts; ack on other bits is ignored.
  - Selected ack at cycle T+k -> RESPOND with status 00. o_select=0 and o_response_valid=1 from T+k+1.
  - With TIMEOUT_CYCLES>0 and no ack, when counter==TIMEOUT_CYCLES-1 -> RESPOND with status 11. o_select drops the next cycle. o_select is therefore high for exactly TIMEOUT_CYCLES cycles.
  - Ack in the same cycle as the timeout condition: ack wins, status 00.
  - Counter width is clog2(TIMEOUT_CYCLES+1), min 1. The counter never wraps.
- RESPOND:
  - o_response_valid, status and index are held stable until i_response_ready. On the handshake cycle -> IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake. No back-to-back overlap.
- Input stability:
  - The request is sampled only at acceptance.
  - Changes to i_address or i_access during ACCESS/RESPOND have no effect.
- Reset mid-operation: o_select and o_response_valid drop immediately (async); the FSM returns to IDLE.
- Minimum transaction: accept T, select T+1, ack T+1, response valid T+2, ready T+2, next accept T+3.

Test Plan:
- WINDOWS=4, BUS_WIDTH=32, windows [0x00-0x0F],[0x10-0x13],[0x20-0x2F],[0x30-0x3F]. Read 0x12, ack at T+3 -> o_select=0010 at T+1..T+3; response 00, index 1 at T+4.
- Address 0x1A (gap) -> no select; response 01, index 0 at T+1. Address 0x13 (low bits ignored) -> window 1 hit.
- WRITABLE_MASK=4'b1011. Write 0x24 -> response 10, index 2, o_select never asserts. Read 0x24 -> normal OKAY.
- TIMEOUT_CYCLES=16, no ack -> o_select high exactly 16 cycles, then response 11. Ack in the 16th cycle -> status 00. Ack on a wrong bit -> still times out.
- i_response_ready held low 5 cycles -> response valid, status and index stable; o_request_ready=0 and a new valid request is not accepted until after the handshake.
- Assert i_rst_n=0 during ACCESS -> o_select=0 in the same cycle. After release, o_request_ready=1 and a fresh request completes normally.
